// File: rtl/seg_capture.sv
// seg_capture: samples a multiplexed active-low 7-segment display and
// reassembles the four displayed digits into one 16-bit value per frame.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  digit_mask,
  output logic        bad_pattern
);

  localparam logic [7:0] LAST_CNT  = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HELD
  } state_e;

  logic [6:0]  seg_m_q, seg_s_q;
  logic [3:0]  an_m_q, an_s_q;
  logic [10:0] pair_prev_q;
  logic [10:0] pair_s;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] digits_q, digits_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        bad_q, bad_d;

  logic        changed;
  logic        onehot;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        pat_ok;
  logic        capture;

  // Two-flop synchronizer; resets to the "nothing displayed" pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m_q <= '1;
      seg_s_q <= '1;
      an_m_q  <= '1;
      an_s_q  <= '1;
    end else begin
      seg_m_q <= seg;
      seg_s_q <= seg_m_q;
      an_m_q  <= an;
      an_s_q  <= an_m_q;
    end
  end

  assign pair_s  = {an_s_q, seg_s_q};
  assign changed = (pair_s != pair_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_prev_q <= '1;
    end else begin
      pair_prev_q <= pair_s;
    end
  end

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    unique case (an_s_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  always_comb begin
    pat_ok = 1'b1;
    nib    = 4'h0;
    unique case (seg_s_q)
      7'h01:   nib = 4'h0;
      7'h4F:   nib = 4'h1;
      7'h12:   nib = 4'h2;
      7'h06:   nib = 4'h3;
      7'h4C:   nib = 4'h4;
      7'h24:   nib = 4'h5;
      7'h20:   nib = 4'h6;
      7'h0F:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h0C:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h60:   nib = 4'hB;
      7'h31:   nib = 4'hC;
      7'h42:   nib = 4'hD;
      7'h30:   nib = 4'hE;
      7'h38:   nib = 4'hF;
      default: pat_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the number of equal samples before the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!onehot) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (changed || (state_q == IDLE)) begin
      state_d = COUNT;
      cnt_d   = 8'd1;
    end else if (state_q == COUNT) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == LAST_CNT) begin
        state_d = HELD;
      end
    end
  end

  always_comb begin
    capture = onehot && !changed && (state_q == COUNT) && (cnt_q == LAST_CNT);
  end

  // Completing the frame loads value with the just-written nibble included.
  always_comb begin
    digits_d = digits_q;
    mask_d   = mask_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    bad_d    = 1'b0;
    if (capture) begin
      if (pat_ok) begin
        digits_d[{idx, 2'b00} +: 4] = nib;
        mask_d = mask_q | (4'b0001 << idx);
        if (mask_d == 4'hF) begin
          value_d = digits_d;
          valid_d = 1'b1;
          mask_d  = '0;
        end
      end else if (seg_s_q != SEG_BLANK) begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      bad_q    <= bad_d;
    end
  end

  assign value       = value_q;
  assign valid       = valid_q;
  assign digit_mask  = mask_q;
  assign bad_pattern = bad_q;

endmodule
